// File: rtl/data_mem.sv
// data_mem: single-port synchronous word memory with registered read data.
// Optional per-word even parity with a registered parity_err output when MEM_PARITY_EN is defined.
module data_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] address,
    input  logic              mode,
`ifdef MEM_PARITY_EN
    output logic              parity_err,
`endif
    output logic [DATA_W-1:0] data_out
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    function automatic logic even_par(input logic [DATA_W-1:0] word);
        return ^word;
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] data_out_q;
    logic [DATA_W-1:0] data_out_d;
    logic [DATA_W-1:0] rd_word_s;
    logic              in_range_s;
    logic              wr_en_s;

    assign in_range_s = ({1'b0, address} < DEPTH_L);
    assign wr_en_s    = (mode == 1'b0) && in_range_s;
    assign data_out   = data_out_q;

    // Fetch the addressed word; out-of-range reads yield zero.
    always_comb begin
        rd_word_s = '0;
        if (in_range_s) begin
            rd_word_s = mem_q[address];
        end else begin
            rd_word_s = '0;
        end
    end

    // Read data updates only on read edges and otherwise holds.
    always_comb begin
        data_out_d = data_out_q;
        case (mode)
            1'b1:    data_out_d = rd_word_s;
            1'b0:    data_out_d = data_out_q;
            default: data_out_d = data_out_q;
        endcase
    end

    // Storage array: cleared while in reset, written on in-range write edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_s) begin
            mem_q[address] <= data_in;
        end
    end

    // Registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q <= '0;
        end else begin
            data_out_q <= data_out_d;
        end
    end

`ifdef MEM_PARITY_EN
    logic par_q [DEPTH];
    logic rd_par_s;
    logic parity_err_q;
    logic parity_err_d;

    assign parity_err = parity_err_q;

    // Stored parity bit for the addressed word and the resulting error flag.
    always_comb begin
        rd_par_s     = 1'b0;
        parity_err_d = 1'b0;
        if (mode && in_range_s) begin
            rd_par_s     = par_q[address];
            parity_err_d = (rd_par_s != even_par(rd_word_s));
        end else begin
            rd_par_s     = 1'b0;
            parity_err_d = 1'b0;
        end
    end

    // Parity bit storage, written alongside the data word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                par_q[i] <= 1'b0;
            end
        end else if (wr_en_s) begin
            par_q[address] <= even_par(data_in);
        end
    end

    // Registered parity error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end
`endif

endmodule

// File: tb/tb_data_mem.sv
// Scoreboard testbench for data_mem: expected read data is queued when an
// operation is driven and compared after the sampling edge.
module tb_data_mem;

    logic        clk;
    logic        rst_n;
    logic [31:0] data_in;
    logic [7:0]  address;
    logic        mode;
    logic [31:0] data_out;
`ifdef MEM_PARITY_EN
    logic        parity_err;
    logic        exp_par_q[$];
`endif

    int checks;
    int errors;

    logic [31:0] model_mem [256];
    logic [31:0] exp_last;
    logic [31:0] exp_q[$];

    data_mem dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .address  (address),
        .mode     (mode),
`ifdef MEM_PARITY_EN
        .parity_err(parity_err),
`endif
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
        exp_last = 32'h0;
    endtask

    // One operation: drive at negedge, predict, then compare 1 ns after the rising edge.
    task automatic do_op(input logic m, input logic [7:0] a, input logic [31:0] d,
                         input string name, input logic exp_perr);
        logic [31:0] exp;
        @(negedge clk);
        mode    = m;
        address = a;
        data_in = d;
        if (m) exp_last = model_mem[a];
        else   model_mem[a] = d;
        exp_q.push_back(exp_last);
`ifdef MEM_PARITY_EN
        exp_par_q.push_back(m ? exp_perr : 1'b0);
`endif
        @(posedge clk);
        #1;
        // mid-cycle input noise must have no effect
        address = ~a;
        data_in = ~d;
        exp = exp_q.pop_front();
        checks++;
        if (data_out !== exp) begin
            errors++;
            $display("FAIL %s: data_out=%h expected=%h", name, data_out, exp);
        end
`ifdef MEM_PARITY_EN
        begin
            logic ep;
            ep = exp_par_q.pop_front();
            checks++;
            if (parity_err !== ep) begin
                errors++;
                $display("FAIL %s_parity: parity_err=%b expected=%b", name, parity_err, ep);
            end
        end
`endif
    endtask

    task automatic async_reset_pulse(input string name);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        checks++;
        if (data_out !== 32'h0) begin
            errors++;
            $display("FAIL %s: data_out=%h expected=%h", name, data_out, 32'h0);
        end
`ifdef MEM_PARITY_EN
        checks++;
        if (parity_err !== 1'b0) begin
            errors++;
            $display("FAIL %s_parity: parity_err=%b expected=0", name, parity_err);
        end
`endif
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        mode = 1'b1; address = 8'd0; data_in = 32'h0;
        rst_n = 1'b1;
        model_clear();
        async_reset_pulse("reset_immediate");
        do_op(1'b1, 8'd7, 32'h0, "reset_read7", 1'b0);
    endtask

    task automatic test_write_read();
        do_op(1'b0, 8'd2, 32'd30, "wr_a2", 1'b0);
        do_op(1'b0, 8'd4, 32'd40, "wr_a4", 1'b0);
        do_op(1'b1, 8'd2, 32'h0, "rd_a2", 1'b0);
        do_op(1'b1, 8'd4, 32'h0, "rd_a4", 1'b0);
    endtask

    task automatic test_write_hold();
        do_op(1'b1, 8'd2, 32'h0, "rd_a2_again", 1'b0);
        do_op(1'b0, 8'd2, 32'd99, "wr_hold", 1'b0);
        do_op(1'b1, 8'd2, 32'h0, "rd_a2_new", 1'b0);
    endtask

    task automatic test_boundaries();
        do_op(1'b0, 8'd255, 32'hFFFF_FFFF, "wr_a255", 1'b0);
        do_op(1'b0, 8'd0, 32'h0000_0001, "wr_a0", 1'b0);
        do_op(1'b1, 8'd255, 32'h0, "rd_a255", 1'b0);
        do_op(1'b1, 8'd0, 32'h0, "rd_a0", 1'b0);
        do_op(1'b1, 8'd1, 32'h0, "rd_a1_zero", 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            logic [7:0]  a;
            logic [31:0] d;
            a = 8'($urandom_range(8, 250));
            d = $urandom;
            do_op(1'b0, a, d, "b2b_wr", 1'b0);
            do_op(1'b1, a, 32'h0, "b2b_rd", 1'b0);
        end
    endtask

    task automatic test_async_reset();
        do_op(1'b0, 8'd3, 32'd55, "wr_a3", 1'b0);
        do_op(1'b1, 8'd3, 32'h0, "rd_a3_pre", 1'b0);
        async_reset_pulse("midop_reset");
        do_op(1'b0, 8'd9, 32'd77, "post_reset_wr_holds0", 1'b0);
        do_op(1'b1, 8'd3, 32'h0, "rd_a3_lost", 1'b0);
        do_op(1'b1, 8'd255, 32'h0, "rd_a255_lost", 1'b0);
    endtask

`ifdef MEM_PARITY_EN
    task automatic test_parity();
        do_op(1'b0, 8'd5, 32'h0000_00A5, "par_wr", 1'b0);
        do_op(1'b1, 8'd5, 32'h0, "par_rd_ok", 1'b0);
        @(negedge clk);
        dut.mem_q[5] = dut.mem_q[5] ^ 32'h0000_0001;
        model_mem[5] = model_mem[5] ^ 32'h0000_0001;
        do_op(1'b1, 8'd5, 32'h0, "par_rd_flip", 1'b1);
        do_op(1'b0, 8'd6, 32'h1, "par_wr_clears", 1'b0);
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_write_read();
        test_write_hold();
        test_boundaries();
        test_back_to_back();
        test_async_reset();
`ifdef MEM_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
